// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding access with WAIT_CYCLES wait states, then a one-cycle data_ok.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [3:0]  lat_sel;
  logic [31:0] lat_wdata;

  logic [31:0] mem [2**ADDR_W];

  logic              accept;
  logic              cur_wr;
  logic [1:0]        cur_size;
  logic [31:0]       cur_addr;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] lat_idx;
  logic              range_err;
  logic              align_err;
  logic              acc_err;
  logic              enter_resp;

  assign accept = addr_ok && req;

  // With zero wait states RESP is entered on the accept edge, before the latches hold the request.
  assign cur_wr   = (state == IDLE) ? wr   : lat_wr;
  assign cur_size = (state == IDLE) ? size : lat_size;
  assign cur_addr = (state == IDLE) ? addr : lat_addr;
  assign cur_idx  = cur_addr[ADDR_W+1:2];
  assign lat_idx  = lat_addr[ADDR_W+1:2];

  assign range_err = (cur_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = ((cur_size == 2'd1) && cur_addr[0]) ||
                     (cur_size[1] && (cur_addr[1:0] != 2'd0));
`else
  logic unused_bits;
  assign align_err   = 1'b0;
  assign unused_bits = ^{cur_size, cur_addr[1:0]};
`endif

  assign acc_err    = range_err | align_err;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = rst;
        if (req && rst) begin
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        data_ok   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_sel   <= 4'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= 4'(WAIT_CYCLES);
      lat_wr    <= wr;
      lat_size  <= size;
      lat_addr  <= addr;
      lat_sel   <= sel;
      lat_wdata <= wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers are only non-zero while the response is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      err   <= acc_err;
      rdata <= (!cur_wr && !acc_err) ? mem[cur_idx] : 32'd0;
    end else if (state == RESP) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end
  end

  // Writes commit on the edge leaving RESP; the registered err blocks bad accesses.
  always_ff @(posedge clk) begin
    if (rst && (state == RESP) && lat_wr && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_sel[i]) begin
          mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int W      = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .sel(sel), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [16];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check("reset addr_ok", addr_ok, 0);
      check("reset data_ok", data_ok, 0);
      check("reset rdata", rdata, 0);
      check("reset err", err, 0);
    end else if (data_ok) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious data_ok: got 1, expected no response (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("resp rdata", rdata, e.rdata);
        check("resp err", err, e.err);
        check("resp latency cycle", cyc, e.cyc);
      end
    end else begin
      check("idle rdata", rdata, 0);
      check("idle err", err, 0);
    end
  end

  // Drives one request; the model is updated only once the DUT accepts it.
  task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input bit abort);
    exp_t e;
    bit   oob;
    bit   mis;
    bit   accepted;
    int   idx;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; sel = s; wdata = d;
    accepted = 1'b0;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (addr_ok) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: got addr_ok=0, expected 1 (addr %h)", a);
      req = 1'b0;
      return;
    end
    oob = (a >= (32'd1 << (ADDR_W + 2)));
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = ((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0));
`endif
    idx = int'(a / 4) % 16;
    e.err   = oob || mis;
    e.rdata = 32'd0;
    e.cyc   = cyc + W + 1;
    if (!abort) begin
      if (!e.err) begin
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
          e.rdata = ref_mem[idx];
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1 req = 1'b0;
    if (abort) begin
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 check("addr_ok after reset", addr_ok, 1);

    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'(i * 4), 4'hF, $urandom, 1'b0);
    issue(1'b1, 2'd2, 32'h30, 4'hF, 32'h0, 1'b0);

    issue(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 1'b0);

    issue(1'b1, 2'd2, 32'h20, 4'hF, 32'h11223344, 1'b0);
    issue(1'b1, 2'd0, 32'h22, 4'b0100, 32'h00AB0000, 1'b0);
    issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 32'h20, 4'h0, 32'h55555555, 1'b0);
    issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 1'b0);

    issue(1'b0, 2'd2, 32'h00001000, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 32'h00001000, 4'hF, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b0);

    issue(1'b0, 2'd2, 32'h22, 4'h0, 32'h0, 1'b0);

    issue(1'b1, 2'd2, 32'h30, 4'hF, 32'hCAFEF00D, 1'b1);
    issue(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
        if (a < 32'h1000) a = a + 32'h1000;
      end else begin
        a = 32'($urandom_range(0, 63));
      end
      issue(1'($urandom), 2'($urandom), a, 4'($urandom), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (W + 6) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
